// File: rtl/tb_stream_bridge.sv
// tb_stream_bridge
//   Multi-channel stimulus/capture bridge between testbench file readers and
//   writers and a device under test. Stimulus words are buffered in a FIFO and
//   released onto dut_in once per sample period. DUT outputs are sampled at
//   the same rate into a capture FIFO for the writer side.
//
//   Operating phases: IDLE (no ticks), PRIME (wait until PRIME_LEVEL stimulus
//   words are buffered) and RUN (divider produces sample ticks).
//
// Ports
//   clk          single simulation clock
//   rst          synchronous active-high reset
//   enable       1 = stream, 0 = return to IDLE (FIFOs and dut_in kept)
//   stim_valid   stimulus word offered
//   stim_ready   stimulus FIFO can accept a word (low during rst)
//   stim_data    stimulus word, channel k = bits [k*WIDTH +: WIDTH]
//   stim_level   stimulus FIFO occupancy
//   dut_in       registered drive to the DUT inputs
//   dut_out      DUT outputs, sampled on each tick
//   cap_valid    capture word available (first-word fall-through)
//   cap_ready    writer consumes the capture head
//   cap_data     capture FIFO head, valid while cap_valid=1
//   sample_tick  one-cycle strobe per sample period while in RUN
//   underrun     sticky: a tick found the stimulus FIFO empty
//   overflow     sticky: a tick found the capture FIFO full and not draining
module tb_stream_bridge #(
  parameter int CHANNELS      = 2,
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 16,
  parameter int SAMPLE_DIV    = 4,
  parameter int PRIME_LEVEL   = 2,
  parameter int UNDERRUN_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        stim_valid,
  output logic                        stim_ready,
  input  logic [CHANNELS*WIDTH-1:0]   stim_data,
  output logic [$clog2(DEPTH+1)-1:0]  stim_level,
  output logic [CHANNELS*WIDTH-1:0]   dut_in,
  input  logic [CHANNELS*WIDTH-1:0]   dut_out,
  output logic                        cap_valid,
  input  logic                        cap_ready,
  output logic [CHANNELS*WIDTH-1:0]   cap_data,
  output logic                        sample_tick,
  output logic                        underrun,
  output logic                        overflow
);

  localparam int WORD_W = CHANNELS * WIDTH;
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;

  logic [WORD_W-1:0]  stim_mem [DEPTH];
  logic [PTR_W-1:0]   stim_wr;
  logic [PTR_W-1:0]   stim_rd;
  logic               stim_full;
  logic               stim_empty;
  logic               stim_push;
  logic               stim_pop;

  logic [WORD_W-1:0]  cap_mem [DEPTH];
  logic [PTR_W-1:0]   cap_wr;
  logic [PTR_W-1:0]   cap_rd;
  logic [LVL_W-1:0]   cap_level;
  logic               cap_full;
  logic               cap_push;
  logic               cap_pop;

  logic               tick;

  // Value driven onto dut_in when a tick finds no stimulus: either keep the
  // last word (so the DUT sees a steady input) or force zero.
  function automatic logic [WORD_W-1:0] underrun_fill(input logic [WORD_W-1:0] hold);
    if (UNDERRUN_MODE != 0) begin
      return '0;
    end
    return hold;
  endfunction

  // ---------------------------------------------------------------------
  // Control: sample tick decode and FIFO handshakes
  // ---------------------------------------------------------------------
  always_comb begin
    tick       = (state == RUN) && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    stim_full  = (stim_level == LVL_W'(DEPTH));
    stim_empty = (stim_level == '0);
    stim_ready = !rst && !stim_full;
    stim_push  = stim_valid && stim_ready;
    // No bypass: a word pushed in a tick cycle is not visible to that tick.
    stim_pop   = tick && !stim_empty;

    cap_full   = (cap_level == LVL_W'(DEPTH));
    cap_valid  = (cap_level != '0);
    cap_pop    = cap_valid && cap_ready;
    // A full FIFO still takes the sample when the head leaves in the same cycle.
    cap_push   = tick && (!cap_full || cap_ready);
    cap_data   = cap_mem[cap_rd];

    sample_tick = tick;
  end

  // ---------------------------------------------------------------------
  // Phase FSM and sample divider
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
    end else if (!enable) begin
      state   <= IDLE;
      div_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          state   <= PRIME;
          div_cnt <= '0;
        end
        PRIME: begin
          // Entry to RUN restarts the divider so the first tick lands a full
          // sample period later.
          if (stim_level >= LVL_W'(PRIME_LEVEL)) begin
            state <= RUN;
          end
          div_cnt <= '0;
        end
        RUN: begin
          if (tick) begin
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          div_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus FIFO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stim_wr    <= '0;
      stim_rd    <= '0;
      stim_level <= '0;
    end else begin
      if (stim_push) begin
        stim_wr <= stim_wr + PTR_W'(1);
      end
      if (stim_pop) begin
        stim_rd <= stim_rd + PTR_W'(1);
      end
      stim_level <= stim_level + LVL_W'(stim_push) - LVL_W'(stim_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (stim_push) begin
      stim_mem[stim_wr] <= stim_data;
    end
  end

  // ---------------------------------------------------------------------
  // Tick stage: stimulus head -> dut_in, sticky status flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_in   <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (tick) begin
        if (!stim_empty) begin
          dut_in <= stim_mem[stim_rd];
        end else begin
          dut_in   <= underrun_fill(dut_in);
          underrun <= 1'b1;
        end
        if (cap_full && !cap_ready) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Capture FIFO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_wr    <= '0;
      cap_rd    <= '0;
      cap_level <= '0;
    end else begin
      if (cap_push) begin
        cap_wr <= cap_wr + PTR_W'(1);
      end
      if (cap_pop) begin
        cap_rd <= cap_rd + PTR_W'(1);
      end
      cap_level <= cap_level + LVL_W'(cap_push) - LVL_W'(cap_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (cap_push) begin
      cap_mem[cap_wr] <= dut_out;
    end
  end

endmodule
